// File: rtl/seg_decode_capture.sv
// -----------------------------------------------------------------------------
// seg_decode_capture
//
// Watches a multiplexed seven-segment display bus and rebuilds the digit values
// it shows. The segment pattern and the digit enables are registered once.
// A pattern has to stay unchanged for STABLE_CYCLES consecutive samples before
// it is decoded. It is then written into the position selected by the one-hot
// digit enable. Illegal patterns and multi-hot enables set a sticky error flag.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous reset, active low
//   seg_in[7:0]  segment pattern, bit7=a ... bit1=g, bit0=dp (dp ignored)
//   an[N-1:0]    digit enables, one-hot while a digit is driven
//   clr          synchronous clear of digits, digit_valid and err
//   digits       decoded value per position, digit i at [4i+3:4i]
//   digit_valid  position i has been captured with a legal pattern
//   upd_valid    one-cycle pulse per successful capture
//   upd_idx      position of the capture (qualified by upd_valid)
//   upd_val      decoded value of the capture (qualified by upd_valid)
//   err          sticky error: illegal pattern or multi-hot enable at capture
// -----------------------------------------------------------------------------
module seg_decode_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                seg_in,
  input  logic [NUM_DIGITS-1:0]     an,
  input  logic                      clr,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic [NUM_DIGITS-1:0]     digit_valid,
  output logic                      upd_valid,
  output logic [2:0]                upd_idx,
  output logic [3:0]                upd_val,
  output logic                      err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  // Returns {legal, value} for the seven segment bits a..g.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h7E:   r = {1'b1, 4'd0};
      7'h30:   r = {1'b1, 4'd1};
      7'h6D:   r = {1'b1, 4'd2};
      7'h79:   r = {1'b1, 4'd3};
      7'h33:   r = {1'b1, 4'd4};
      7'h5B:   r = {1'b1, 4'd5};
      7'h5F:   r = {1'b1, 4'd6};
      7'h70:   r = {1'b1, 4'd7};
      7'h7F:   r = {1'b1, 4'd8};
      7'h73:   r = {1'b1, 4'd9};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  // Stability counter increment that sticks at the capture threshold.
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 8'd1;
  endfunction

  function automatic logic [2:0] onehot_idx(input logic [NUM_DIGITS-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  state_t                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [7:0]                seg_q, seg_d, seg_prev_q, seg_prev_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d, an_prev_q, an_prev_d;
  logic [4*NUM_DIGITS-1:0]   digits_q, digits_d;
  logic [NUM_DIGITS-1:0]     valid_q, valid_d;
  logic                      upd_valid_q, upd_valid_d;
  logic [2:0]                upd_idx_q, upd_idx_d;
  logic [3:0]                upd_val_q, upd_val_d;
  logic                      err_q, err_d;

  logic                      chg;
  logic                      an_zero;
  logic                      an_onehot;
  logic                      capture;
  logic [4:0]                dec;

  // Stage 0: input sampling, and the previous sample for change detection
  always_comb begin
    seg_d      = seg_in;
    an_d       = an;
    seg_prev_d = seg_q;
    an_prev_d  = an_q;
  end

  // Stage 1: stability tracking on the registered sample
  always_comb begin
    chg       = (seg_q != seg_prev_q) || (an_q != an_prev_q);
    an_zero   = (an_q == '0);
    an_onehot = !an_zero && ((an_q & (an_q - NUM_DIGITS'(1))) == '0);

    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;

    if (chg) begin
      cnt_d   = 8'd0;
      state_d = an_zero ? IDLE : TRACK;
    end else begin
      case (state_q)
        IDLE: begin
          // Only reachable with a non-blank sample if the change was missed;
          // restart a full stability window.
          cnt_d = sat_inc(cnt_q);
          if (!an_zero) begin
            cnt_d   = 8'd0;
            state_d = TRACK;
          end
        end
        TRACK: begin
          cnt_d = sat_inc(cnt_q);
          if (cnt_d == CNT_MAX) begin
            capture = 1'b1;
            state_d = HELD;
          end
        end
        HELD: begin
          cnt_d = sat_inc(cnt_q);
        end
        default: begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Stage 2: decode and capture into the digit store
  always_comb begin
    dec         = decode_seg(seg_q[7:1]);
    digits_d    = digits_q;
    valid_d     = valid_q;
    err_d       = err_q;
    upd_valid_d = 1'b0;
    upd_idx_d   = upd_idx_q;
    upd_val_d   = upd_val_q;

    // clr takes priority over a capture landing on the same edge.
    if (clr) begin
      digits_d = '0;
      valid_d  = '0;
      err_d    = 1'b0;
    end else if (capture) begin
      if (an_onehot && dec[4]) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (an_q[i]) begin
            digits_d[4*i +: 4] = dec[3:0];
            valid_d[i]         = 1'b1;
          end
        end
        upd_valid_d = 1'b1;
        upd_idx_d   = onehot_idx(an_q);
        upd_val_d   = dec[3:0];
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      seg_q       <= 8'd0;
      an_q        <= '0;
      seg_prev_q  <= 8'd0;
      an_prev_q   <= '0;
      digits_q    <= '0;
      valid_q     <= '0;
      upd_valid_q <= 1'b0;
      upd_idx_q   <= 3'd0;
      upd_val_q   <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      seg_prev_q  <= seg_prev_d;
      an_prev_q   <= an_prev_d;
      digits_q    <= digits_d;
      valid_q     <= valid_d;
      upd_valid_q <= upd_valid_d;
      upd_idx_q   <= upd_idx_d;
      upd_val_q   <= upd_val_d;
      err_q       <= err_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign upd_valid   = upd_valid_q;
  assign upd_idx     = upd_idx_q;
  assign upd_val     = upd_val_q;
  assign err         = err_q;

endmodule

// File: tb/tb_seg_decode_capture.sv
// -----------------------------------------------------------------------------
// tb_seg_decode_capture
//
// Directed bench for seg_decode_capture with STABLE_CYCLES=4, NUM_DIGITS=8.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_seg_decode_capture;

  logic        clk;
  logic        reset;
  logic [7:0]  seg_in;
  logic [7:0]  an;
  logic        clr;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic        upd_valid;
  logic [2:0]  upd_idx;
  logic [3:0]  upd_val;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  int         pulse_cnt = 0;
  logic [2:0] last_idx  = 3'd0;
  logic [3:0] last_val  = 4'd0;

  seg_decode_capture #(
    .STABLE_CYCLES(4),
    .NUM_DIGITS(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .seg_in(seg_in),
    .an(an),
    .clr(clr),
    .digits(digits),
    .digit_valid(digit_valid),
    .upd_valid(upd_valid),
    .upd_idx(upd_idx),
    .upd_val(upd_val),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (upd_valid) begin
      pulse_cnt = pulse_cnt + 1;
      last_idx  = upd_idx;
      last_val  = upd_val;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] pat [8];
  int         p0;

  initial begin
    pat[0] = 8'hFC; pat[1] = 8'h60; pat[2] = 8'hDA; pat[3] = 8'hF3;
    pat[4] = 8'h66; pat[5] = 8'hB6; pat[6] = 8'hBE; pat[7] = 8'hE0;

    reset  = 1'b0;
    clr    = 1'b0;
    seg_in = 8'h00;
    an     = 8'h00;

    // Reset state
    #2;
    check("rst_digits", 64'(digits), 64'h0);
    check("rst_valid", 64'(digit_valid), 64'h0);
    check("rst_upd_valid", 64'(upd_valid), 64'h0);
    check("rst_upd_idx", 64'(upd_idx), 64'h0);
    check("rst_upd_val", 64'(upd_val), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    step(2);

    // Single digit, latency: settled before edge 1, pulse after edge 5
    reset  = 1'b1;
    an     = 8'h04;
    seg_in = 8'hDA;
    p0     = pulse_cnt;
    for (int e = 1; e <= 4; e++) begin
      step(1);
      check("lat_no_pulse_early", 64'(upd_valid), 64'h0);
    end
    step(1);
    check("lat_pulse_edge5", 64'(upd_valid), 64'h1);
    check("lat_upd_idx", 64'(upd_idx), 64'h2);
    check("lat_upd_val", 64'(upd_val), 64'h2);
    check("lat_digit2", 64'(digits[11:8]), 64'h2);
    check("lat_valid", 64'(digit_valid), 64'h04);
    step(1);
    check("lat_pulse_one_cycle", 64'(upd_valid), 64'h0);
    step(4);
    check("lat_single_pulse", 64'(pulse_cnt - p0), 64'h1);

    // Toggling input never becomes stable
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_valid", 64'(digit_valid), 64'h0);
    an = 8'h01;
    p0 = pulse_cnt;
    for (int k = 0; k < 10; k++) begin
      seg_in = k[0] ? 8'h60 : 8'hFC;
      step(2);
    end
    check("toggle_no_pulse", 64'(pulse_cnt - p0), 64'h0);
    check("toggle_valid", 64'(digit_valid), 64'h0);
    check("toggle_err", 64'(err), 64'h0);

    // Illegal pattern: g segment only
    an     = 8'h80;
    seg_in = 8'h02;
    p0     = pulse_cnt;
    step(6);
    check("illegal_err", 64'(err), 64'h1);
    check("illegal_no_pulse", 64'(pulse_cnt - p0), 64'h0);
    check("illegal_valid", 64'(digit_valid), 64'h0);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("illegal_clr_err", 64'(err), 64'h0);

    // Scan all eight positions, values 0..7 (position 3 carries dp=1)
    p0 = pulse_cnt;
    for (int i = 0; i < 8; i++) begin
      an     = 8'(1 << i);
      seg_in = pat[i];
      step(6);
      check("scan_idx", 64'(last_idx), 64'(i));
      check("scan_val", 64'(last_val), 64'(i));
    end
    check("scan_pulses", 64'(pulse_cnt - p0), 64'h8);
    check("scan_digits", 64'(digits), 64'h76543210);
    check("scan_valid", 64'(digit_valid), 64'hFF);

    // Overwrite position 0 with 9, then hold long enough to expose counter wrap
    an     = 8'h01;
    seg_in = 8'hE6;
    p0     = pulse_cnt;
    step(300);
    check("recap_digits", 64'(digits), 64'h76543219);
    check("recap_single_pulse", 64'(pulse_cnt - p0), 64'h1);

    // Multi-hot enable: error, no write; then blank display
    an     = 8'h03;
    seg_in = 8'hFC;
    p0     = pulse_cnt;
    step(6);
    check("multihot_err", 64'(err), 64'h1);
    check("multihot_digits", 64'(digits), 64'h76543219);
    check("multihot_valid", 64'(digit_valid), 64'hFF);
    check("multihot_no_pulse", 64'(pulse_cnt - p0), 64'h0);
    an = 8'h00;
    step(6);
    check("blank_no_pulse", 64'(pulse_cnt - p0), 64'h0);
    check("blank_err_sticky", 64'(err), 64'h1);
    check("blank_digits", 64'(digits), 64'h76543219);

    // Reset in the middle of a stability window
    an     = 8'h10;
    seg_in = 8'hE6;
    step(3);
    reset = 1'b0;
    #1;
    check("midrst_digits", 64'(digits), 64'h0);
    check("midrst_valid", 64'(digit_valid), 64'h0);
    check("midrst_err", 64'(err), 64'h0);
    check("midrst_upd_val", 64'(upd_val), 64'h0);
    step(2);
    check("midrst_no_pulse", 64'(upd_valid), 64'h0);
    reset = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step(1);
      check("midrst_no_early_pulse", 64'(upd_valid), 64'h0);
    end
    step(1);
    check("midrst_pulse", 64'(upd_valid), 64'h1);
    check("midrst_idx", 64'(upd_idx), 64'h4);
    check("midrst_val", 64'(upd_val), 64'h9);

    // clr on the capture edge wins and suppresses the pulse
    step(2);
    an     = 8'h02;
    seg_in = 8'hE0;
    p0     = pulse_cnt;
    step(4);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clrcap_no_pulse", 64'(upd_valid), 64'h0);
    check("clrcap_digits", 64'(digits), 64'h0);
    check("clrcap_valid", 64'(digit_valid), 64'h0);
    step(4);
    check("clrcap_held_no_recapture", 64'(pulse_cnt - p0), 64'h0);
    check("clrcap_valid_after", 64'(digit_valid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_decode_capture.md
SEG_DECODE_CAPTURE -- requirements
Module: seg_decode_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4 (range 2..255): consecutive identical samples required before a capture.
REQ-002 Parameter NUM_DIGITS, default 8: number of digit positions (an width).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 seg_in  input  8  segment pattern, active-high, bit7=a … bit1=g, bit0=dp.
REQ-006 an  input  NUM_DIGITS  digit enable, active-high, one-hot when a digit is driven.
REQ-007 clr  input  1  synchronous clear of captured digits and error flag.
REQ-008 digits  output  4*NUM_DIGITS  decoded value per position; digit i at bits [4i+3:4i].
REQ-009 digit_valid  output  NUM_DIGITS  bit i set once position i has been captured with a legal pattern.
REQ-010 upd_valid  output  1  one-cycle pulse per capture event.
REQ-011 upd_idx  output  3  position index of the capture; valid with upd_valid.
REQ-012 upd_val  output  4  decoded value of the capture; valid with upd_valid.
REQ-013 err  output  1  sticky error flag.

Function
REQ-014 seg_in and an SHALL be registered once (seg_q, an_q) before any decode or comparison.
REQ-015 Decode SHALL compare seg_q[7:1] only, dp ignored: FC→0, 60→1, DA→2, F2→3, 66→4, B6→5, BE→6, E0→7, FE→8, E6→9 (values as full byte with dp=0).
REQ-016 FSM states: IDLE, TRACK, HELD.
REQ-017 In every state, a registered sample differing from the previous one in seg_q or an_q SHALL zero the stability counter and enter TRACK (or IDLE if an_q is all-zero).
REQ-018 IDLE: an_q all-zero (blank); no capture, no error; leaves to TRACK when an_q becomes non-zero.
REQ-019 TRACK: counter increments each cycle the sample is unchanged; on reaching STABLE_CYCLES-1 the block SHALL capture once and enter HELD.
REQ-020 Capture with one-hot an_q and legal pattern: write digits[idx], set digit_valid[idx], pulse upd_valid with upd_idx/upd_val for exactly one cycle.
REQ-021 Capture with illegal pattern or multi-hot an_q: set err, no write, no upd_valid, digit_valid unchanged.
REQ-022 HELD: no further capture until the sample changes; a steady input yields exactly one upd_valid.
REQ-023 Latency: inputs settled before edge N → upd_valid high in the cycle after edge N+STABLE_CYCLES (STABLE_CYCLES=4: settled before edge 1, pulse after edge 5).
REQ-024 Counter SHALL saturate, never wrap, regardless of how long input is steady.
REQ-025 Recapture of an already valid position SHALL overwrite its value.
REQ-026 clr SHALL zero digits, digit_valid, err next edge; if clr coincides with a capture, clr wins and upd_valid is suppressed; FSM/counter unaffected.
REQ-027 Index for NUM_DIGITS≤8 SHALL be the position of the single set bit of an_q.

Reset
REQ-028 reset=0 SHALL immediately force: digits=0, digit_valid=0, upd_valid=0, upd_idx=0, upd_val=0, err=0, counter=0, seg_q=0, an_q=0, state IDLE.
REQ-029 Reset asserted mid-TRACK SHALL discard partial stability; after release a full STABLE_CYCLES window is required before capture.

Verification
REQ-030 an=8'h04, seg_in=8'hDA held 10 cycles → single upd_valid after edge 5, upd_idx=2, upd_val=2, digits[11:8]=2, digit_valid=8'h04.
REQ-031 an=8'h01, seg_in toggles FC/60 every 2 cycles for 20 cycles → no upd_valid, digit_valid=0, err=0.
REQ-032 an=8'h80, seg_in=8'h02 (g only) held 6 cycles → err=1, no upd_valid, digit_valid=0; then clr=1 one cycle → err=0.
REQ-033 Scan 8 positions, each an one-hot with values 0..7 held 6 cycles → eight upd_valid pulses, digits=32'h76543210, digit_valid=8'hFF.
REQ-034 an=8'h03, seg_in=8'hFC held 6 cycles → err=1, no write; an=0 held 6 cycles → no capture, no new error.
REQ-035 an=8'h10, seg_in=8'hE6, reset=0 after 3 stable cycles, released → no pulse before release, upd_valid exactly STABLE_CYCLES+1 edges after release, upd_val=9.
